// File: rtl/cct_change_logger.sv
`timescale 1ns/1ps
// Logs every change of the monitored bus with an 8-bit cycle stamp into a FWFT FIFO; capture lands 1 cycle after the change.
// Reader pops via rd_valid/rd_ready; a change arriving when full (and not popped the same cycle) is dropped and counted.
module cct_change_logger #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         cct_output,
    input  logic                     enable,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [7:0]               rd_stamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [15:0]              checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [7:0]       stamp;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [WIDTH-1:0] prev_q;
    logic [7:0]       tstamp;
    logic             capture;
    logic             pop;
    logic             push;
    logic             drop;

    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign capture  = enable && (cct_output != prev_q);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = capture && ((count != FULL) || pop);
    assign drop     = capture && !push;

    // Head is masked while empty so stale storage never leaks out after reset.
    assign rd_data  = rd_valid ? mem[head].dat   : '0;
    assign rd_stamp = rd_valid ? mem[head].stamp : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {cct_output, tstamp};
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            prev_q     <= '0;
            tstamp     <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            checksum   <= '0;
        end else begin
            prev_q <= cct_output;
            tstamp <= tstamp + 8'd1;
            if (push) begin
                tail     <= tail + 1'b1;
                checksum <= checksum + 16'(cct_output);
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cct_change_logger.sv
`timescale 1ns/1ps
module tb_cct_change_logger;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic        clk;
    logic        clear;
    logic [7:0]  cct_output;
    logic        enable;
    logic        rd_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [7:0]  rd_stamp;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;

    cct_change_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clear      (clear),
        .cct_output (cct_output),
        .enable     (enable),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_stamp   (rd_stamp),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of logged entries plus plain counters.
    typedef struct {
        logic [7:0] d;
        logic [7:0] s;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_prev;
    int         m_ts;
    logic       m_ovf;
    int         m_drop;
    int         m_sum;

    typedef struct {
        logic [7:0] cct;
        logic       en;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic [7:0] e_stamp;
        int         e_count;
        logic       e_ovf;
        int         e_drop;
        int         e_sum;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(logic [7:0] c, logic e, logic r, logic v, logic [7:0] d,
                                logic [7:0] s, int n, logic o, int dr, int sm);
        vec_t t;
        t.cct = c; t.en = e; t.rdy = r; t.e_valid = v; t.e_data = d; t.e_stamp = s;
        t.e_count = n; t.e_ovf = o; t.e_drop = dr; t.e_sum = sm;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev = '0;
        m_ts   = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
        m_sum  = 0;
    endtask

    task automatic model_step();
        int n;
        bit pop;
        bit cap;
        ent_t e;
        n   = mq.size();
        pop = (n > 0) && rd_ready;
        cap = enable && (cct_output != m_prev);
        if (pop) void'(mq.pop_front());
        if (cap) begin
            if (n < DEPTH || pop) begin
                e.d = cct_output;
                e.s = 8'(m_ts);
                mq.push_back(e);
                m_sum = (m_sum + int'(cct_output)) % 65536;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_prev = cct_output;
        m_ts   = (m_ts + 1) % 256;
    endtask

    task automatic check_model(input string tag);
        bit ne;
        ne = (mq.size() > 0);
        chk({tag, " rd_valid"}, rd_valid, ne);
        chk({tag, " rd_data"}, rd_data, ne ? mq[0].d : 8'h00);
        chk({tag, " rd_stamp"}, rd_stamp, ne ? mq[0].s : 8'h00);
        chk({tag, " count"}, count, mq.size());
        chk({tag, " overflow"}, overflow, m_ovf);
        chk({tag, " drop_count"}, drop_count, m_drop);
        chk({tag, " checksum"}, checksum, m_sum);
    endtask

    task automatic apply(input logic [7:0] c, input logic e, input logic r);
        cct_output = c;
        enable     = e;
        rd_ready   = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " rd_valid"}, rd_valid, 0);
        chk({tag, " rd_data"}, rd_data, 0);
        chk({tag, " rd_stamp"}, rd_stamp, 0);
        chk({tag, " count"}, count, 0);
        chk({tag, " overflow"}, overflow, 0);
        chk({tag, " drop_count"}, drop_count, 0);
        chk({tag, " checksum"}, checksum, 0);
    endtask

    task automatic do_reset();
        clear      = 1'b0;
        cct_output = '0;
        enable     = 1'b1;
        rd_ready   = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        #1;
        clear = 1'b1;
    endtask

    task automatic run_table(input string nm);
        foreach (tab[i]) begin
            apply(tab[i].cct, tab[i].en, tab[i].rdy);
            chk($sformatf("%s[%0d] rd_valid", nm, i), rd_valid, tab[i].e_valid);
            chk($sformatf("%s[%0d] rd_data", nm, i), rd_data, tab[i].e_data);
            chk($sformatf("%s[%0d] rd_stamp", nm, i), rd_stamp, tab[i].e_stamp);
            chk($sformatf("%s[%0d] count", nm, i), count, tab[i].e_count);
            chk($sformatf("%s[%0d] overflow", nm, i), overflow, tab[i].e_ovf);
            chk($sformatf("%s[%0d] drop_count", nm, i), drop_count, tab[i].e_drop);
            chk($sformatf("%s[%0d] checksum", nm, i), checksum, tab[i].e_sum);
        end
        tab.delete();
    endtask

    initial begin
        int rp;
        logic [7:0] c;

        // Single change at cycle 3, held, then popped.
        do_reset();
        tab.push_back(mk(8'h00, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 0));
        tab.push_back(mk(8'h00, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 0));
        tab.push_back(mk(8'h00, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 0));
        tab.push_back(mk(8'h5A, 1, 0, 1, 8'h5A, 8'd3, 1, 0, 0, 'h5A));
        tab.push_back(mk(8'h5A, 1, 0, 1, 8'h5A, 8'd3, 1, 0, 0, 'h5A));
        tab.push_back(mk(8'h5A, 1, 0, 1, 8'h5A, 8'd3, 1, 0, 0, 'h5A));
        tab.push_back(mk(8'h5A, 1, 1, 0, 8'h00, 8'd0, 0, 0, 0, 'h5A));
        run_table("single");

        // Ten consecutive changes into an 8-deep FIFO, then drain in order.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            int k;
            k = (i + 1 < 8) ? i + 1 : 8;
            tab.push_back(mk(8'(i + 1), 1, 0, 1, 8'h01, 8'd0, k, i >= 8,
                             (i >= 8) ? i - 7 : 0, k * (k + 1) / 2));
        end
        for (int j = 0; j < 8; j++) begin
            tab.push_back(mk(8'h0A, 1, 1, j < 7, (j < 7) ? 8'(j + 2) : 8'h00,
                             (j < 7) ? 8'(j + 1) : 8'h00, 7 - j, 1, 2, 36));
        end
        run_table("burst");

        // Full FIFO: push and pop in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) apply(8'(i + 1), 1, 0);
        apply(8'h55, 1, 1);
        chk("fullpp count", count, 8);
        chk("fullpp rd_data", rd_data, 8'h02);
        chk("fullpp rd_stamp", rd_stamp, 8'd1);
        chk("fullpp overflow", overflow, 0);
        chk("fullpp drop_count", drop_count, 0);
        chk("fullpp checksum", checksum, 36 + 'h55);
        for (int i = 0; i < 7; i++) apply(8'h55, 1, 1);
        chk("fullpp tail rd_data", rd_data, 8'h55);
        chk("fullpp tail rd_stamp", rd_stamp, 8'd8);
        chk("fullpp tail count", count, 1);

        // Disabled changes are not logged and do not reappear on re-enable.
        do_reset();
        apply(8'h10, 0, 0);
        apply(8'h20, 0, 0);
        apply(8'h20, 1, 0);
        apply(8'h20, 1, 0);
        chk("enable held count", count, 0);
        chk("enable held rd_valid", rd_valid, 0);
        apply(8'h21, 1, 0);
        chk("enable next count", count, 1);
        chk("enable next rd_data", rd_data, 8'h21);
        chk("enable next rd_stamp", rd_stamp, 8'd4);
        chk("enable next checksum", checksum, 'h21);

        // Timestamp wrap, then saturate the drop counter.
        do_reset();
        for (int i = 0; i < 260; i++) apply(8'h00, 1, 1);
        apply(8'h77, 1, 0);
        chk("wrap rd_stamp", rd_stamp, 8'd4);
        chk("wrap rd_data", rd_data, 8'h77);
        for (int i = 0; i < 39; i++) apply(8'h77, 1, 0);
        for (int i = 0; i < 310; i++) apply((i % 2 == 1) ? 8'h33 : 8'hCC, 1, 0);
        chk("sat drop_count", drop_count, 255);
        chk("sat overflow", overflow, 1);
        chk("sat count", count, 8);
        check_model("sat");

        // Asynchronous clear between clock edges.
        do_reset();
        for (int i = 0; i < 5; i++) apply(8'((i + 1) * 'h11), 1, 0);
        chk("midclr pre count", count, 5);
        #3;
        clear = 1'b0;
        #1;
        check_all_zero("midclr");
        model_reset();
        #2;
        clear = 1'b1;
        apply(8'h00, 1, 0);
        check_model("midclr post");

        // Randomized traffic against the queue model, with varying reader pace.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            rp = (p == 0) ? 10 : (p == 1) ? 50 : (p == 2) ? 90 : 30;
            for (int i = 0; i < 500; i++) begin
                c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cct_output;
                apply(c, $urandom_range(0, 7) != 0, $urandom_range(0, 99) < rp);
                check_model($sformatf("rand p%0d c%0d", p, i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cct_change_logger.md
# cct_change_logger

Downstream consumer of the student circuit's 8-bit output. Watches `cct_output` every clock, records each value change together with an 8-bit cycle timestamp into a small first-word-fall-through FIFO, and hands entries to a reader through a valid/ready handshake. Also keeps a sticky overflow flag, a saturating drop counter and a running 16-bit checksum of logged values, so a bench or display stage can inspect the circuit's output history without sampling it every cycle.

## Interface
- `WIDTH`, 8: data width of the monitored bus.
- `DEPTH`, 8: FIFO entries; power of 2, at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset, asynchronous, active-low; clock is `clk`, reset is `clear`.
- `cct_output`  in  WIDTH  monitored bus (output of the student circuit).
- `enable`  in  1  logging enable; 0 suppresses capture only.
- `rd_ready`  in  1  reader accepts the head entry this cycle.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_data`  out  WIDTH  head entry's captured value.
- `rd_stamp`  out  8  head entry's timestamp.
- `count`  out  log2(DEPTH)+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a capture was dropped.
- `drop_count`  out  8  dropped captures, saturates at 255.
- `checksum`  out  16  sum of all accepted values, mod 2^16.

## Operation
- `prev_q`: register loaded with `cct_output` every cycle (independent of `enable`); reset 0.
- `tstamp`: free-running 8-bit counter, +1 every cycle, wraps 255 -> 0; reset 0.
- Capture event in a cycle: `enable`=1 and `cct_output` != `prev_q`.
- Pop: `rd_valid` && `rd_ready`.
- Write accepted when a capture occurs and (`count` < DEPTH or pop in the same cycle). Entry stores {`cct_output`, current `tstamp`} at tail.
- Capture with `count`=DEPTH and no pop: dropped; FIFO untouched; `overflow` <= 1; `drop_count` +1 unless already 255.
- Simultaneous push and pop at any occupancy (including full): `count` unchanged, head advances, new entry at tail.
- Pop while empty: impossible (`rd_valid`=0); `rd_ready` ignored.
- `checksum` <= `checksum` + zero-extended value on every accepted write only; wraps mod 2^16.
- `overflow` and `drop_count` are cleared only by reset.
- Pointers are log2(DEPTH) bits and wrap naturally; `count` tracks full/empty.
- `rd_data`/`rd_stamp` driven from head storage (FWFT); contents undefined-but-stable when `rd_valid`=0. Drive 0 when empty for determinism.
- `enable` low: no captures, `prev_q` still tracks, so re-enabling does not log a stale change.

## Timing
- Reset (`clear`=0, asynchronous): `rd_valid`=0, `rd_data`=0, `rd_stamp`=0, `count`=0, `overflow`=0, `drop_count`=0, `checksum`=0, `prev_q`=0, `tstamp`=0, pointers 0. Effective immediately, mid-operation included; FIFO contents discarded.
- Capture latency 1 cycle: value differing from `prev_q` at edge k is written at edge k; `rd_valid`=1 and head visible after edge k when FIFO was empty.
- Timestamp recorded is `tstamp` value just before edge k.
- Pop at edge k: next head (or `rd_valid`=0) visible after edge k.
- First value after reset is logged only if nonzero (compared with `prev_q`=0).
- A value held for many cycles produces exactly one entry.
- `count`, `overflow`, `drop_count`, `checksum` all update at the same edge as the causing event.

## Test plan
- Reset, `enable`=1, drive 0x00 then 0x5A at cycle 3, hold -> one entry {0x5A, stamp 3}, `count`=1, `checksum`=0x005A, no further entries.
- Drive 0x01,0x02,...,0x0A on consecutive cycles, `rd_ready`=0 -> `count`=8, entries 0x01..0x08 in order, `overflow`=1, `drop_count`=2, `checksum`=0x0024.
- Full FIFO, `rd_ready`=1 with a new change same cycle -> `count` stays 8, head advances, no drop, `drop_count` unchanged.
- `enable`=0, change 0x10 -> 0x20, then `enable`=1 with bus held 0x20 -> no entry logged; next change to 0x21 logs one entry.
- Run 300 cycles, change bus at cycle 260 -> stamp 4 (wrap); force 300 drops -> `drop_count`=255.
- Assert `clear`=0 mid-stream between edges with `count`=5 -> all outputs 0 immediately, before next `clk` edge.
